// File: rtl/l1_trig_pkg.sv
// Shared constants and lane helpers for the L1 trigger stream packer.
// Event word: {timestamp[31:0], 8'h0, pend[7:0], beam mask[15:0]}.
package l1_trig_pkg;

  localparam int EVT_WIDTH    = 64;
  localparam int EVT_MASK_LSB = 0;
  localparam int EVT_PEND_LSB = 16;
  localparam int EVT_TS_LSB   = 32;

  // Monitor pulse at the default 16-bit lane / 12-bit sample geometry.
  localparam logic [15:0] MON_PULSE = 16'h7FF0;

  // Pulse for any geometry: a 0 MSB, SAMPLE_BITS-1 ones, then zero padding.
  function automatic logic [31:0] mon_pulse(input int lane_bits, input int sample_bits);
    logic [31:0] ones;
    ones = (32'd1 << (sample_bits - 1)) - 32'd1;
    return ones << (lane_bits - sample_bits);
  endfunction

  // Lane helpers work on one zero-extended lane (lane_bits <= 32).
  function automatic logic [31:0] unpack_lanes(input logic [31:0] lane,
                                               input int lane_bits, input int sample_bits);
    return lane >> (lane_bits - sample_bits);
  endfunction

  function automatic logic [31:0] pack_lanes(input logic [31:0] sample,
                                             input int lane_bits, input int sample_bits);
    return sample << (lane_bits - sample_bits);
  endfunction

endpackage

// File: rtl/l1_evt_fifo.sv
// First-word-fall-through event FIFO; head word is visible whenever not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module l1_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // A push while full is refused even if the head leaves this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/l1_trigger_stream_packer.sv
// ADC unpack, per-beam trigger gating with holdoff, timestamped event FIFO and DAC monitor.
// Define L1_DEBUG_TAP_EN to add the dbg_sel_i/dbg_tdata/dbg_tvalid channel tap.
module l1_trigger_stream_packer
  import l1_trig_pkg::*;
#(
  parameter int NCHAN        = 8,
  parameter int NSAMP        = 8,
  parameter int LANE_BITS    = 16,
  parameter int SAMPLE_BITS  = 12,
  parameter int NBEAMS       = 2,
  parameter int HOLDOFF_BITS = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NCHAN*NSAMP*LANE_BITS-1:0]   adc_tdata,
  input  logic [NCHAN-1:0]                   adc_tvalid,
  output logic [NCHAN-1:0]                   adc_tready,
  output logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] dat_o,
  output logic                               dat_valid_o,
  input  logic [NBEAMS-1:0]                  trig_i,
  input  logic [NBEAMS-1:0]                  trig_en_i,
  input  logic [HOLDOFF_BITS-1:0]            holdoff_i,
  output logic [63:0]                        evt_tdata,
  output logic                               evt_tvalid,
  input  logic                               evt_tready,
  output logic [NSAMP*LANE_BITS-1:0]         mon_tdata,
  output logic                               mon_tvalid,
  output logic [15:0]                        drop_count_o
`ifdef L1_DEBUG_TAP_EN
  ,
  input  logic [$clog2(NCHAN)-1:0]           dbg_sel_i,
  output logic [NSAMP*LANE_BITS-1:0]         dbg_tdata,
  output logic                               dbg_tvalid
`endif
);

  localparam int NLANE = NCHAN * NSAMP;
  localparam int NMON  = (NBEAMS < NSAMP) ? NBEAMS : NSAMP;
  localparam logic [LANE_BITS-1:0] PULSE = LANE_BITS'(mon_pulse(LANE_BITS, SAMPLE_BITS));

  logic                               rdy_q;
  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] dat_q, dat_d;
  logic                               dat_valid_q;
  logic [31:0]                        ts_q;
  logic [HOLDOFF_BITS-1:0]            hold_q [NBEAMS];
  logic [HOLDOFF_BITS-1:0]            hold_d [NBEAMS];
  logic [NBEAMS-1:0]                  g, g_r_q, mask2_q;
  logic [31:0]                        ts_r_q, ts2_q;
  logic [NSAMP*LANE_BITS-1:0]         mon_q, mon_d;
  logic                               mon_valid_q;
  logic                               push2_q;
  logic [7:0]                         pend_q, pend_d;
  logic [15:0]                        drop_q, drop_d;
  logic [EVT_WIDTH-1:0]               evt_w;
  logic                               fifo_full, fifo_empty, pop, accept, drop;

  always_comb begin
    dat_d = '0;
    for (int l = 0; l < NLANE; l++) begin
      dat_d[l*SAMPLE_BITS +: SAMPLE_BITS] = SAMPLE_BITS'(unpack_lanes(
        32'(adc_tdata[l*LANE_BITS +: LANE_BITS]), LANE_BITS, SAMPLE_BITS));
    end
  end

  // A beam fires only when enabled and its dead time has fully run out.
  always_comb begin
    g = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      g[b] = trig_i[b] & trig_en_i[b] & (hold_q[b] == '0);
      if (g[b])                hold_d[b] = holdoff_i;
      else if (hold_q[b] != '0) hold_d[b] = hold_q[b] - HOLDOFF_BITS'(1);
      else                     hold_d[b] = hold_q[b];
    end
  end

  always_comb begin
    mon_d = '0;
    for (int b = 0; b < NMON; b++) begin
      if (g[b]) mon_d[b*LANE_BITS +: LANE_BITS] = PULSE;
    end
  end

  // pend is sampled at the FIFO write so it reflects every earlier drop.
  always_comb begin
    evt_w = '0;
    evt_w[EVT_MASK_LSB +: NBEAMS] = mask2_q;
    evt_w[EVT_PEND_LSB +: 8]      = pend_q;
    evt_w[EVT_TS_LSB +: 32]       = ts2_q;
  end

  assign accept = push2_q & ~fifo_full;
  assign drop   = push2_q & fifo_full;

  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    if (accept)                     pend_d = '0;
    else if (drop && pend_q != '1)  pend_d = pend_q + 8'd1;
    if (drop && drop_q != '1)       drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q       <= 1'b0;
      dat_q       <= '0;
      dat_valid_q <= 1'b0;
      ts_q        <= '0;
      for (int b = 0; b < NBEAMS; b++) hold_q[b] <= '0;
      g_r_q       <= '0;
      ts_r_q      <= '0;
      mon_q       <= '0;
      mon_valid_q <= 1'b0;
      push2_q     <= 1'b0;
      mask2_q     <= '0;
      ts2_q       <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
    end else begin
      rdy_q       <= 1'b1;
      dat_q       <= dat_d;
      dat_valid_q <= &adc_tvalid;
      ts_q        <= ts_q + 32'd1;
      for (int b = 0; b < NBEAMS; b++) hold_q[b] <= hold_d[b];
      g_r_q       <= g;
      ts_r_q      <= ts_q;
      mon_q       <= mon_d;
      mon_valid_q <= 1'b1;
      push2_q     <= |g_r_q;
      mask2_q     <= g_r_q;
      ts2_q       <= ts_r_q;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
    end
  end

  // Event port: valid is the FIFO non-empty flag only, never a function of tready.
  assign evt_tvalid = ~fifo_empty;
  assign pop        = evt_tvalid & evt_tready;

  l1_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_WIDTH)
  ) u_evt_fifo (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .push_i (push2_q),
    .data_i (evt_w),
    .pop_i  (pop),
    .data_o (evt_tdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign adc_tready   = {NCHAN{rdy_q}};
  assign dat_o        = dat_q;
  assign dat_valid_o  = dat_valid_q;
  assign mon_tdata    = mon_q;
  assign mon_tvalid   = mon_valid_q;
  assign drop_count_o = drop_q;

`ifdef L1_DEBUG_TAP_EN
  logic [NSAMP*LANE_BITS-1:0] dbg_q, dbg_d;
  logic                       dbg_valid_q;

  always_comb begin
    dbg_d = '0;
    if (int'(dbg_sel_i) < NCHAN) begin
      for (int s = 0; s < NSAMP; s++) begin
        dbg_d[s*LANE_BITS +: LANE_BITS] = LANE_BITS'(pack_lanes(
          32'(dat_q[(int'(dbg_sel_i)*NSAMP + s)*SAMPLE_BITS +: SAMPLE_BITS]),
          LANE_BITS, SAMPLE_BITS));
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dbg_q       <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_q       <= dbg_d;
      dbg_valid_q <= dat_valid_q;
    end
  end

  assign dbg_tdata  = dbg_q;
  assign dbg_tvalid = dbg_valid_q;
`else
  // Without the tap, dat_q feeds only dat_o.
`endif

endmodule

// File: tb/tb_l1_trigger_stream_packer.sv
// Directed bench for l1_trigger_stream_packer: unpack, gating/holdoff, event FIFO, drops, reset.
// Expected events queue up when triggers are driven and are compared as the event port pops them.
module tb_l1_trigger_stream_packer;

  localparam int NCHAN = 8, NSAMP = 8, LANE_BITS = 16, SAMPLE_BITS = 12, NBEAMS = 2;

  logic                               aclk;
  logic                               aresetn;
  logic [NCHAN*NSAMP*LANE_BITS-1:0]   adc_tdata;
  logic [NCHAN-1:0]                   adc_tvalid;
  logic [NCHAN-1:0]                   adc_tready;
  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] dat_o;
  logic                               dat_valid_o;
  logic [NBEAMS-1:0]                  trig_i, trig_en_i;
  logic [7:0]                         holdoff_i;
  logic [63:0]                        evt_tdata;
  logic                               evt_tvalid, evt_tready;
  logic [NSAMP*LANE_BITS-1:0]         mon_tdata;
  logic                               mon_tvalid;
  logic [15:0]                        drop_count_o;
`ifdef L1_DEBUG_TAP_EN
  logic [2:0]                         dbg_sel_i;
  logic [NSAMP*LANE_BITS-1:0]         dbg_tdata;
  logic                               dbg_tvalid;
`endif

  l1_trigger_stream_packer dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .adc_tdata   (adc_tdata),
    .adc_tvalid  (adc_tvalid),
    .adc_tready  (adc_tready),
    .dat_o       (dat_o),
    .dat_valid_o (dat_valid_o),
    .trig_i      (trig_i),
    .trig_en_i   (trig_en_i),
    .holdoff_i   (holdoff_i),
    .evt_tdata   (evt_tdata),
    .evt_tvalid  (evt_tvalid),
    .evt_tready  (evt_tready),
    .mon_tdata   (mon_tdata),
    .mon_tvalid  (mon_tvalid),
    .drop_count_o(drop_count_o)
`ifdef L1_DEBUG_TAP_EN
    ,
    .dbg_sel_i   (dbg_sel_i),
    .dbg_tdata   (dbg_tdata),
    .dbg_tvalid  (dbg_tvalid)
`endif
  );

  // Clock and reset-relative edge counter (edge_n = timestamp seen by the next edge)
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int edge_n;
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  // Scoreboard
  logic [63:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk_evt(input logic [31:0] ts, input logic [7:0] pend,
                                         input logic [15:0] mask);
    return {ts, 8'h00, pend, mask};
  endfunction

  function automatic logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] unpack_ref(
      input logic [NCHAN*NSAMP*LANE_BITS-1:0] d);
    logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] r;
    r = '0;
    for (int l = 0; l < NCHAN*NSAMP; l++) r[l*12 +: 12] = d[l*16 + 4 +: 12];
    return r;
  endfunction

  always @(negedge aclk) begin
    if (aresetn && evt_tvalid && evt_tready) begin
      logic [63:0] e;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 'x;
      chk("evt", 512'(evt_tdata), 512'(e));
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic rand_adc();
    for (int i = 0; i < NCHAN*NSAMP*LANE_BITS/32; i++) adc_tdata[i*32 +: 32] = $urandom();
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      step(1);
      k++;
    end
    chk(tag, 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [NCHAN*NSAMP*LANE_BITS-1:0] d_prev;
  logic [NSAMP*LANE_BITS-1:0]       dbg_exp;

  initial begin
    aresetn    = 1'b1;
    adc_tdata  = '0;
    adc_tvalid = '0;
    trig_i     = '0;
    trig_en_i  = '0;
    holdoff_i  = '0;
    evt_tready = 1'b1;
`ifdef L1_DEBUG_TAP_EN
    dbg_sel_i  = 3'd5;
`endif
    #1 aresetn = 1'b0;
    step(2);
    chk("rst_tready",  512'(adc_tready), 512'(0));
    chk("rst_dvalid",  512'(dat_valid_o), 512'(0));
    chk("rst_evalid",  512'(evt_tvalid), 512'(0));
    chk("rst_mvalid",  512'(mon_tvalid), 512'(0));
    chk("rst_drops",   512'(drop_count_o), 512'(0));
    aresetn = 1'b1;
    step(1);
    chk("tready_on",   512'(adc_tready), 512'(8'hFF));
    chk("mvalid_on",   512'(mon_tvalid), 512'(1));

    // Unpack and dat_valid
    rand_adc();
    adc_tdata[15:0] = 16'hABC0;
    adc_tvalid = '1;
    d_prev = adc_tdata;
    step(1);
    chk("dat_s0",      512'(dat_o[11:0]), 512'(12'hABC));
    chk("dat_all",     512'(dat_o), 512'(unpack_ref(d_prev)));
    chk("dvalid_hi",   512'(dat_valid_o), 512'(1));
    rand_adc();
    adc_tvalid[3] = 1'b0;
    step(1);
    chk("dvalid_lo",   512'(dat_valid_o), 512'(0));
    chk("dat_upd",     512'(dat_o), 512'(unpack_ref(adc_tdata)));
`ifdef L1_DEBUG_TAP_EN
    for (int s = 0; s < NSAMP; s++) dbg_exp[s*16 +: 16] = d_prev[(5*NSAMP + s)*16 +: 16] & 16'hFFF0;
    chk("dbg_data",    512'(dbg_tdata), 512'(dbg_exp));
    chk("dbg_valid",   512'(dbg_tvalid), 512'(1));
`else
    dbg_exp = '0;
`endif
    adc_tvalid = '1;
    step(1);
    chk("dvalid_back", 512'(dat_valid_o), 512'(1));

    // Holdoff 3 on beam 0 held high: fires every 4 cycles
    trig_en_i = 2'b11;
    holdoff_i = 8'd3;
    trig_i    = 2'b01;
    for (int i = 0; i < 12; i++) begin
      logic fire;
      fire = (i % 4 == 0);
      if (fire) exp_q.push_back(mk_evt(32'(edge_n), 8'd0, 16'h0001));
      step(1);
      chk("mon_hold", 512'(mon_tdata), fire ? 512'(16'h7FF0) : 512'(0));
    end
    trig_i = '0;
    wait_drain("drain_hold");

    // Enable mask passes only beam 1
    trig_en_i = 2'b10;
    trig_i    = 2'b11;
    exp_q.push_back(mk_evt(32'(edge_n), 8'd0, 16'h0002));
    step(1);
    trig_i = '0;
    chk("mon_beam1", 512'(mon_tdata), 512'(32'h7FF0_0000));
    wait_drain("drain_mask");

    // Back-pressure: 20 triggers into a 16-deep FIFO
    trig_en_i  = 2'b11;
    holdoff_i  = 8'd0;
    evt_tready = 1'b0;
    step(1);
    for (int i = 0; i < 20; i++) begin
      trig_i = 2'b01;
      if (i < 16) exp_q.push_back(mk_evt(32'(edge_n), 8'd0, 16'h0001));
      step(1);
      trig_i = '0;
      step(1);
    end
    step(4);
    chk("drops_4",      512'(drop_count_o), 512'(4));
    chk("stall_valid",  512'(evt_tvalid), 512'(1));
    chk("stall_head",   512'(evt_tdata), 512'(exp_q[0]));
    step(3);
    chk("stall_stable", 512'(evt_tdata), 512'(exp_q[0]));
    trig_i     = 2'b01;
    evt_tready = 1'b1;
    exp_q.push_back(mk_evt(32'(edge_n), 8'd4, 16'h0001));
    step(1);
    trig_i = '0;
    wait_drain("drain_full");

    // Holdoff 0 fires every cycle; then reset in the middle of draining
    evt_tready = 1'b0;
    trig_i     = 2'b01;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk_evt(32'(edge_n), 8'd0, 16'h0001));
      step(1);
    end
    trig_i = '0;
    step(3);
    chk("drops_kept", 512'(drop_count_o), 512'(4));
    evt_tready = 1'b1;
    step(2);
    aresetn = 1'b0;
    #1;
    chk("rst_evt_valid", 512'(evt_tvalid), 512'(0));
    chk("rst_evt_data",  512'(evt_tdata), 512'(0));
    exp_q.delete();
    step(1);
    chk("rst2_drops",  512'(drop_count_o), 512'(0));
    chk("rst2_dat",    512'(dat_o), 512'(0));
    chk("rst2_mon",    512'(mon_tdata), 512'(0));
    chk("rst2_tready", 512'(adc_tready), 512'(0));

    // Timestamp restarts at 0; trigger-to-valid latency of two edges
    aresetn = 1'b1;
    trig_i  = 2'b10;
    exp_q.push_back(mk_evt(32'd0, 8'd0, 16'h0002));
    step(1);
    trig_i = '0;
    chk("lat_k",   512'(evt_tvalid), 512'(0));
    step(1);
    chk("lat_k1",  512'(evt_tvalid), 512'(0));
    step(1);
    chk("lat_k2",  512'(evt_tvalid), 512'(1));
    wait_drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l1_trigger_stream_packer.md
Name: l1_trigger_stream_packer

Overview:
- Parametrised successor to the fixed 8-channel, 2-beam L1 trigger wrapper.
- Unpacks NCHAN AXI4-Stream ADC lanes into SAMPLE_BITS samples and registers them for the L1 core.
- Gates the core's per-beam trigger bits with enable masks and per-beam holdoff, timestamps each trigger, and queues it in a FIFO drained over a back-pressured AXI4-Stream event port.
- Also drives a DAC monitor stream showing gated triggers as full-scale pulses.

Parameters:
- NCHAN, 8, ADC channels.
- NSAMP, 8, samples (lanes) per beat.
- LANE_BITS, 16, lane width; sample is MSB-aligned within the lane.
- SAMPLE_BITS, 12, sample width (≤ LANE_BITS).
- NBEAMS, 2, trigger beams (1..16).
- HOLDOFF_BITS, 8, holdoff counter width.
- FIFO_DEPTH, 16, event FIFO depth (power of two, ≥ 2).

Ports:
- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- adc_tdata  in  NCHAN*NSAMP*LANE_BITS  ADC beats; channel c at [c*NSAMP*LANE_BITS +: NSAMP*LANE_BITS].
- adc_tvalid  in  NCHAN  per-channel valid.
- adc_tready  out  NCHAN  0 in reset, all 1 otherwise.
- dat_o  out  NCHAN*NSAMP*SAMPLE_BITS  unpacked samples to the L1 core.
- dat_valid_o  out  1  dat_o valid.
- trig_i  in  NBEAMS  raw trigger bits from the L1 core.
- trig_en_i  in  NBEAMS  per-beam enable mask.
- holdoff_i  in  HOLDOFF_BITS  per-beam dead cycles after firing.
- evt_tdata  out  64  event word.
- evt_tvalid  out  1  event valid.
- evt_tready  in  1  event ready.
- mon_tdata  out  NSAMP*LANE_BITS  DAC monitor beat.
- mon_tvalid  out  1  constant 1 out of reset.
- drop_count_o  out  16  saturating count of dropped events.

Behaviour:
- Reset (async assert, sync release): every output 0; FIFO flushed; timestamp, holdoff and drop counters cleared. Reset mid-stream discards queued events with no partial beat.
- Unpack: sample s of channel c = lane bits [s*LANE_BITS + LANE_BITS-SAMPLE_BITS +: SAMPLE_BITS]. Latency 1 cycle.
- dat_valid_o is registered: 1 iff all adc_tvalid were 1 on the sampling edge. dat_o still updates every cycle.
- Timestamp: 32-bit free-running counter, 0 on the first cycle after reset release, wraps 0xFFFFFFFF→0.
- Gating: g[b] = trig_i[b] & trig_en_i[b] & (hold[b]==0).
  - If g[b]: hold[b] ← holdoff_i. Else if hold[b]≠0: decrement.
  - A beam firing at cycle t may next fire at t+holdoff_i+1. holdoff_i=0 allows firing every cycle.
  - holdoff_i is sampled only at firing.
- Stage 1 registers g (g_r) and the timestamp.
- Stage 2, if g_r≠0, pushes evt = {ts[31:0], 8'h0, pend[7:0], 16-bit zero-extended g_r}.
  - pend is an 8-bit saturating count of events dropped since the last accepted push; cleared when a push is accepted.
- FIFO is first-word fall-through. Latency: trig_i sampled on edge k gives evt_tvalid high after edge k+2 (FIFO empty, evt_tready=1).
- Full: fullness is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs. On drop: pend+1 and drop_count_o+1, each saturating (0xFF and 0xFFFF).
- AXI4-Stream rules:
  - evt_tdata is stable while evt_tvalid=1 and evt_tready=0.
  - evt_tvalid does not depend combinationally on evt_tready.
  - Pop on tvalid&tready.
  - Empty FIFO gives evt_tvalid=0.
- Monitor: for lane b < min(NBEAMS,NSAMP), lane = g_r[b] ? {SAMPLE_BITS-1 ones at top with a 0 MSB, zero pad} : 0. This is 16'h7FF0 at defaults. Other lanes are 0. Updated every cycle alongside g_r.

Optional Feature:
- Macro L1_DEBUG_TAP_EN.
- When defined, adds ports:
  - dbg_sel_i  in  $clog2(NCHAN)
  - dbg_tdata  out  NSAMP*LANE_BITS
  - dbg_tvalid  out  1
- dbg_tdata is the selected channel's unpacked samples repacked MSB-aligned with zeroed low bits, registered once after dat_o (2-cycle latency from adc_tdata).
- dbg_tvalid follows dat_valid_o delayed by one cycle.
- An out-of-range dbg_sel_i outputs 0.
- When undefined, these ports and their logic are absent.

Decomposition:
- Package l1_trig_pkg: EVT_WIDTH=64, field offsets (EVT_MASK_LSB=0, EVT_PEND_LSB=16, EVT_TS_LSB=32), MON_PULSE constant, and unpack_lanes/pack_lanes functions.
- Sub-module l1_evt_fifo: synchronous FWFT FIFO with DEPTH and WIDTH parameters, full/empty flags, async active-low reset.

Test Plan:
- Reset, then drive adc c=0 lane 0 = 16'hABC0 with all tvalid=1 → next cycle dat_o sample 0 = 12'hABC and dat_valid_o=1. Deassert adc_tvalid[3] → dat_valid_o=0 one cycle later.
- holdoff_i=3, trig_en_i=2'b11, trig_i[0] held high → events every 4 cycles with mask 0x0001, consecutive timestamps differing by 4. mon lane 0 = 16'h7FF0 on firing cycles only.
- trig_en_i=2'b10, trig_i=2'b11 for 1 cycle → one event, mask 0x0002.
- evt_tready=0, 20 single-cycle triggers spaced 2 apart with FIFO_DEPTH=16 → 16 queued, drop_count_o=4. With evt_tready=1 and a further trigger, its event carries pend=4; queued data drain unchanged and in order.
- Assert aresetn=0 mid-drain → evt_tvalid=0 immediately. After release, timestamp restarts at 0 and the FIFO is empty.
- With L1_DEBUG_TAP_EN and dbg_sel_i=5 → dbg_tdata equals channel-5 lanes with the low 4 bits zeroed, two cycles later.
